poly_rq_to_s3: RTL and testbench
================================

POLY_RQ_TO_S3 -- requirements
Module: poly_rq_to_s3

Interface
REQ-001 SHALL have parameter N, default 701, meaning polynomial length in coefficients.
REQ-002 SHALL have parameter CW, default 13, meaning the mod-q coefficient width (q = 2^CW); only CW = 13 is supported.
REQ-003 SHALL have port clk  input  1  clock; all state updates occur on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  in_coef is valid this cycle.
REQ-006 SHALL have port in_ready  output  1  the block accepts in_coef this cycle.
REQ-007 SHALL have port in_coef  input  CW  mod-q coefficient, unsigned 0..8191, delivered in index order 0..N-1.
REQ-008 SHALL have port out_valid  output  1  out_trit is valid.
REQ-009 SHALL have port out_ready  input  1  the sink accepts out_trit this cycle.
REQ-010 SHALL have port out_trit  output  2  S3 coefficient encoded 0, 1 or 2; code 3 is never driven.
REQ-011 SHALL have port out_last  output  1  out_trit is coefficient N-1.
REQ-012 SHALL have port busy  output  1  a frame is partially loaded or is draining.

Function
REQ-013 SHALL have two states: LOAD and DRAIN.
REQ-014 LOAD: in_ready=1, out_valid=0; each cycle with in_valid&in_ready stores t_i at write index i, then i increments.
REQ-015 t_i SHALL be computed as t_i = ((a mod 3) + a[12]) mod 3, which is the centered lift: for a >= 4096, a-8192 is congruent to a+1 mod 3.
REQ-016 t_i SHALL be stored in an internal N x 2-bit buffer; t_(N-1) SHALL additionally be held in a dedicated register.
REQ-017 Acceptance of coefficient N-1 SHALL move the block to DRAIN on the next cycle, with the read index set to 0; output latency from the last input handshake to the first out_valid is 1 cycle.
REQ-018 DRAIN: in_ready=0, out_valid=1, out_trit = (t_j + 2*t_(N-1)) mod 3 at read index j, and out_last=(j==N-1).
REQ-019 While out_valid=1 and out_ready=0, out_trit and out_last SHALL hold stable and j SHALL NOT advance.
REQ-020 On out_valid&out_ready with j==N-1, the block SHALL return to LOAD next cycle with the write index at 0; the next frame can start one cycle later.
REQ-021 in_valid gaps (bubbles) during LOAD SHALL NOT alter results; in_coef SHALL be ignored when in_ready=0.
REQ-022 busy SHALL equal (state==DRAIN) or (write index != 0).
REQ-023 For index j=N-1, out_trit SHALL be 0, because t + 2t = 3t is congruent to 0.

Reset
REQ-024 While rst=0, on each rising edge: state <- LOAD, write and read indices <- 0, t_(N-1) register <- 0.
REQ-025 While rst=0, out_valid=0, in_ready=0, out_last=0, out_trit=0 and busy=0; buffer contents need not be cleared.
REQ-026 Reset mid-LOAD or mid-DRAIN SHALL discard the partial frame; in the first cycle after rst returns to 1, the block is in LOAD with in_ready=1.

Configuration
REQ-027 With macro PHI_N_REDUCE_EN defined, out_trit SHALL follow REQ-018 (reduction modulo Phi_N).
REQ-028 Without PHI_N_REDUCE_EN, out_trit SHALL equal t_j, the t_(N-1) register SHALL be omitted, and all timing, handshake and out_last behaviour SHALL be unchanged.

Verification
REQ-029 Send an all-zero frame -> 701 trits of 0; out_last is high only on the 701st output; busy falls after the last handshake.
REQ-030 Send a0=1, a1=2, a2=3, a3=8191, a4=4096, all other coefficients 0 -> trits 1,2,0,2,2, then 0 for the rest (macro set or clear).
REQ-031 Send a0=0 and a700=1, all others 0 -> with PHI_N_REDUCE_EN: out0=2, outputs 1..699 = 2, out700=0; without: out0=0, out700=1.
REQ-032 Hold out_ready=0 for 5 cycles at j=10 -> out_trit/out_last stable, no skipped or duplicated index, in_ready=0 throughout DRAIN.
REQ-033 Assert rst=0 for 1 cycle after 300 accepted coefficients, then send a full new frame -> output reflects only the new frame; first out_valid occurs 1 cycle after its 701st handshake.
REQ-034 Drive in_valid with a random 50% duty cycle plus back-to-back frames -> output identical to a gap-free run; the second frame is accepted starting 1 cycle after the first frame's out_last handshake.

Source files
------------

// File: rtl/poly_rq_to_s3.sv
// Converts a frame of N mod-q coefficients into S3 trits via the centered lift.
// Optional PHI_N_REDUCE_EN macro: reduce the trit polynomial modulo Phi_N on output.
module poly_rq_to_s3 #(
  parameter int unsigned N  = 701,
  parameter int unsigned CW = 13
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [CW-1:0] in_coef,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [1:0]    out_trit,
  output logic          out_last,
  output logic          busy
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  typedef enum logic {LOAD, DRAIN} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] wr_idx_q, wr_idx_d;
  logic [IW-1:0] rd_idx_q, rd_idx_d;
  logic [1:0]    buf_q [N];
  logic [1:0]    t_in;
  logic [1:0]    trit_raw;
  logic [1:0]    trit_c;
  logic          in_fire;
  logic          out_fire;

  // Reduce a small value (0..7) modulo 3.
  function automatic logic [1:0] mod3_small(input logic [2:0] v);
    logic [1:0] r;
    case (v)
      3'd1, 3'd4, 3'd7: r = 2'd1;
      3'd2, 3'd5:       r = 2'd2;
      default:          r = 2'd0;
    endcase
    return r;
  endfunction

  // Centered lift: values with the top bit set are negative, and a-2^CW == a+1 (mod 3).
  function automatic logic [1:0] lift(input logic [CW-1:0] a);
    logic [1:0] r;
    r = 2'(a % CW'(3));
    return mod3_small(3'(r) + 3'(a[CW-1]));
  endfunction

  assign t_in     = lift(in_coef);
  assign trit_raw = buf_q[rd_idx_q];

`ifdef PHI_N_REDUCE_EN
  logic [1:0] t_last_q;

  // Subtracting t_(N-1) * Phi_N folds the top coefficient into every position.
  assign trit_c = mod3_small(3'(trit_raw) + {t_last_q, 1'b0});

  always_ff @(posedge clk) begin
    if (!rst) begin
      t_last_q <= 2'd0;
    end else if (in_fire && (wr_idx_q == LAST_IDX)) begin
      t_last_q <= t_in;
    end
  end
`else
  assign trit_c = trit_raw;
`endif

  // Next-state, index and handshake decode.
  always_comb begin
    state_d   = state_q;
    wr_idx_d  = wr_idx_q;
    rd_idx_d  = rd_idx_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_trit  = 2'd0;
    out_last  = 1'b0;
    busy      = 1'b0;
    in_fire   = 1'b0;
    out_fire  = 1'b0;

    if (rst) begin
      busy = (state_q == DRAIN) || (wr_idx_q != '0);
      case (state_q)
        LOAD: begin
          in_ready = 1'b1;
          in_fire  = in_valid;
          if (in_fire) begin
            if (wr_idx_q == LAST_IDX) begin
              state_d  = DRAIN;
              wr_idx_d = '0;
              rd_idx_d = '0;
            end else begin
              wr_idx_d = wr_idx_q + IW'(1);
            end
          end
        end
        DRAIN: begin
          out_valid = 1'b1;
          out_trit  = trit_c;
          out_last  = (rd_idx_q == LAST_IDX);
          out_fire  = out_ready;
          if (out_fire) begin
            if (rd_idx_q == LAST_IDX) begin
              state_d  = LOAD;
              rd_idx_d = '0;
            end else begin
              rd_idx_d = rd_idx_q + IW'(1);
            end
          end
        end
        default: state_d = LOAD;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= LOAD;
      wr_idx_q <= '0;
      rd_idx_q <= '0;
    end else begin
      state_q  <= state_d;
      wr_idx_q <= wr_idx_d;
      rd_idx_q <= rd_idx_d;
    end
  end

  // Trit buffer; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      buf_q[wr_idx_q] <= t_in;
    end
  end

endmodule

// File: tb/tb_poly_rq_to_s3.sv
// Directed bench for poly_rq_to_s3; honours PHI_N_REDUCE_EN when computing expectations.
module tb_poly_rq_to_s3;

  localparam int N = 701;

  typedef struct {
    logic [12:0] coef;
    logic [1:0]  trit;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [12:0] in_coef;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_trit;
  logic        out_last;
  logic        busy;

  int n_checks;
  int n_errors;

  logic [12:0] frame [N];
  logic [1:0]  expv  [N];
  logic [1:0]  got   [N];
  vec_t        vecs  [13];
  logic [1:0]  f2_exp [5];

  poly_rq_to_s3 #(.N(N), .CW(13)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_coef  (in_coef),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_trit (out_trit),
    .out_last (out_last),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      if (n_errors <= 40) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Signed-residue model of the centered lift.
  function automatic logic [1:0] ref_trit(input logic [12:0] a);
    int v;
    int r;
    v = (a >= 13'd4096) ? int'(a) - 8192 : int'(a);
    r = v % 3;
    if (r < 0) r += 3;
    return 2'(r);
  endfunction

  task automatic build_expected();
    logic [1:0] tl;
    tl = ref_trit(frame[N-1]);
    for (int j = 0; j < N; j++) begin
`ifdef PHI_N_REDUCE_EN
      expv[j] = 2'((int'(ref_trit(frame[j])) + 2 * int'(tl)) % 3);
`else
      expv[j] = ref_trit(frame[j]);
`endif
    end
  endtask

  task automatic clear_frame();
    for (int i = 0; i < N; i++) frame[i] = 13'd0;
  endtask

  task automatic random_frame();
    for (int i = 0; i < N; i++) frame[i] = 13'($urandom_range(0, 8191));
  endtask

  task automatic load_frame(input int bubble, input int count);
    int i;
    int cyc;
    logic hs;
    i = 0;
    cyc = 0;
    while (i < count && cyc < N * 8) begin
      in_valid = (bubble != 0) ? ($urandom_range(0, 1) == 1) : 1'b1;
      in_coef  = in_valid ? frame[i] : 13'($urandom_range(0, 8191));
      hs = in_valid && in_ready;
      @(posedge clk);
      #1;
      cyc++;
      if (hs) i++;
    end
    in_valid = 1'b0;
    in_coef  = 13'($urandom_range(0, 8191));
    if (i < count) begin
      check("load_timeout", i, count);
    end else if (count == N) begin
      check("first_valid_latency", int'(out_valid), 1);
      check("in_ready_drain_entry", int'(in_ready), 0);
      check("busy_drain_entry", int'(busy), 1);
    end
  endtask

  task automatic drain_frame(input int rnd_ready, input int hold_at);
    int j;
    int cyc;
    int hold_cnt;
    logic [1:0] ht;
    logic hl;
    logic hs;
    j = 0;
    cyc = 0;
    hold_cnt = 0;
    ht = 2'd0;
    hl = 1'b0;
    while (j < N && cyc < N * 20) begin
      if (j == hold_at && hold_cnt < 5) begin
        if (hold_cnt == 0) begin
          ht = out_trit;
          hl = out_last;
        end else begin
          check("hold_trit_stable", int'(out_trit), int'(ht));
          check("hold_last_stable", int'(out_last), int'(hl));
        end
        out_ready = 1'b0;
        hold_cnt++;
      end else begin
        out_ready = (rnd_ready != 0) ? ($urandom_range(0, 1) == 1) : 1'b1;
      end
      if (out_valid && in_ready) check("in_ready_in_drain", 1, 0);
      hs = out_valid && out_ready;
      if (hs) begin
        got[j] = out_trit;
        check("trit", int'(out_trit), int'(expv[j]));
        check("last", int'(out_last), int'(j == N - 1));
        if (j == hold_at) check("hold_trit_release", int'(out_trit), int'(ht));
        j++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    out_ready = 1'b0;
    if (j < N) begin
      check("drain_timeout", j, N);
    end else begin
      check("busy_after_last", int'(busy), 0);
      check("in_ready_after_last", int'(in_ready), 1);
      check("out_valid_after_last", int'(out_valid), 0);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b0;
    in_valid = 1'b0;
    in_coef = 13'd0;
    out_ready = 1'b0;

    // Coefficient -> trit mapping table, hand computed (index 700 stays 0 so no fold).
    vecs[0]  = '{13'd0,    2'd0};
    vecs[1]  = '{13'd1,    2'd1};
    vecs[2]  = '{13'd2,    2'd2};
    vecs[3]  = '{13'd3,    2'd0};
    vecs[4]  = '{13'd4,    2'd1};
    vecs[5]  = '{13'd100,  2'd1};
    vecs[6]  = '{13'd4095, 2'd0};
    vecs[7]  = '{13'd4096, 2'd2};
    vecs[8]  = '{13'd4097, 2'd0};
    vecs[9]  = '{13'd5000, 2'd0};
    vecs[10] = '{13'd7000, 2'd2};
    vecs[11] = '{13'd8190, 2'd1};
    vecs[12] = '{13'd8191, 2'd2};
    f2_exp = '{2'd1, 2'd2, 2'd0, 2'd2, 2'd2};

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_out_last", int'(out_last), 0);
    check("rst_out_trit", int'(out_trit), 0);
    rst = 1'b1;
    #1;
    check("post_rst_in_ready", int'(in_ready), 1);

    // All-zero frame.
    clear_frame();
    build_expected();
    load_frame(0, N);
    drain_frame(0, -1);

    // Small mixed vector.
    clear_frame();
    frame[0] = 13'd1;
    frame[1] = 13'd2;
    frame[2] = 13'd3;
    frame[3] = 13'd8191;
    frame[4] = 13'd4096;
    build_expected();
    load_frame(0, N);
    drain_frame(0, -1);
    for (int k = 0; k < 5; k++) check("vec030", int'(got[k]), int'(f2_exp[k]));
    check("vec030_tail", int'(got[600]), 0);

    // Only the top coefficient set exercises the Phi_N fold.
    clear_frame();
    frame[N-1] = 13'd1;
    build_expected();
    load_frame(0, N);
    drain_frame(0, -1);
`ifdef PHI_N_REDUCE_EN
    check("fold_out0", int'(got[0]), 2);
    check("fold_out1", int'(got[1]), 2);
    check("fold_out699", int'(got[699]), 2);
    check("fold_out700", int'(got[700]), 0);
`else
    check("fold_out0", int'(got[0]), 0);
    check("fold_out1", int'(got[1]), 0);
    check("fold_out700", int'(got[700]), 1);
`endif

    // Table frame with input bubbles and a 5-cycle stall at j=10.
    clear_frame();
    for (int k = 0; k < 13; k++) frame[k] = vecs[k].coef;
    build_expected();
    load_frame(1, N);
    drain_frame(0, 10);
    for (int k = 0; k < 13; k++) check("table_trit", int'(got[k]), int'(vecs[k].trit));

    // Reset after 300 accepted coefficients discards the partial frame.
    random_frame();
    load_frame(1, 300);
    check("partial_busy", int'(busy), 1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("midload_rst_in_ready", int'(in_ready), 0);
    check("midload_rst_busy", int'(busy), 0);
    check("midload_rst_out_valid", int'(out_valid), 0);
    rst = 1'b1;
    #1;
    check("midload_post_rst_in_ready", int'(in_ready), 1);
    check("midload_post_rst_busy", int'(busy), 0);
    random_frame();
    build_expected();
    load_frame(0, N);
    drain_frame(1, -1);

    // Back-to-back frame with random bubbles, started right after out_last.
    random_frame();
    build_expected();
    load_frame(1, N);
    drain_frame(1, 37);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
